load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before bus error (range 1..1023).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  instruction present in stage
- mem_read  in  1  load (decoded mem_to_reg)
- mem_write  in  1  store
- funct3  in  3  access size/sign
- addr  in  32  ALU effective address
- wdata  in  32  store data (rs2)
- lsu_stall  out  1  hold upstream pipeline
- load_data  out  32  formatted load result
- load_valid  out  1  load_data valid, 1-cycle pulse
- fault  out  1  misaligned/illegal access, 1-cycle pulse
- bus_err  out  1  timeout, 1-cycle pulse
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, WAIT.
REQ-005 Accept in IDLE when valid_in & (mem_read | mem_write) & no fault: latch addr, funct3, wdata, op; next state REQ.
REQ-006 mem_read & mem_write together SHALL be treated as store.
REQ-007 Fault: funct3 in {011,110,111}; halfword with addr[0]=1; word with addr[1:0]!=0; loads 100/101 map to LBU/LHU, stores use 000/001/010 only, other store funct3 faults. Fault SHALL pulse fault for one cycle (registered, cycle after the offending IDLE cycle), no bus request, no stall.
REQ-008 lsu_stall = (state!=IDLE) | (IDLE & accept condition), combinational.
REQ-009 In REQ: dmem_req=1, dmem_we/addr/be/wdata held stable until dmem_gnt; on gnt store -> IDLE, load -> WAIT.
REQ-010 dmem_rvalid outside WAIT SHALL be ignored, including same cycle as gnt.
REQ-011 In WAIT on dmem_rvalid: register formatted data, load_valid=1 next cycle, state -> IDLE.
REQ-012 dmem_addr = {addr[31:2],2'b00}.
REQ-013 Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?1100:0011; word 1111; same for loads.
REQ-014 Store data: byte replicated to all 4 lanes, half replicated to both halves, word as-is; dmem_wdata=0 for loads.
REQ-015 Load format: LB/LBU select lane addr[1:0], sign/zero extend; LH/LHU select half addr[1]; LW as-is.
REQ-016 Latency with zero-wait bus: store stall 2 cycles (accept, REQ); load_valid 3 cycles after accept cycle.
REQ-017 Timeout counter: cleared on accept, increments each cycle in REQ/WAIT; at TIMEOUT_CYCLES pulse bus_err, drop dmem_req, -> IDLE, no load_valid.
REQ-018 load_valid, fault, bus_err SHALL each be high for exactly one cycle per event.

Reset
REQ-019 rst SHALL force: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, load_data=0, load_valid=0, fault=0, bus_err=0, counter=0.
REQ-020 rst in REQ/WAIT SHALL abandon transaction at that edge; later dmem_rvalid SHALL be ignored.

Verification
REQ-021 SW addr=0x104, wdata=0xDEADBEEF, gnt immediate -> dmem_addr=0x104, be=1111, we=1, stall 2 cycles.
REQ-022 SB addr=0x103, wdata=0x000000A5 -> be=1000, dmem_wdata=0xA5A5A5A5.
REQ-023 LB addr=0x202, rdata=0x0080FF00 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x202 -> 0x00000080.
REQ-024 LW addr=0x102 -> fault pulse, dmem_req never asserted, lsu_stall low.
REQ-025 Load, gnt after 3 cycles, rvalid never, TIMEOUT_CYCLES=8 -> bus_err at 8th REQ/WAIT cycle, IDLE, no load_valid.
REQ-026 rst asserted in WAIT, rvalid next cycle -> IDLE, load_valid stays 0, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory instruction at a time, runs a request/grant/rvalid
// handshake on the data bus and returns lane-formatted load data or a fault/timeout pulse.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [9:0] CNT_MAX = 10'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [9:0]  cnt;
    logic        access;
    logic        fault_cond;
    logic        accept;

    function automatic logic bad_access(input logic [2:0] f3, input logic store,
                                        input logic [1:0] lo);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lo[0];
            3'b010:  bad = (lo != 2'b00);
            3'b100:  bad = store;
            3'b101:  bad = store | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3[1:0])
            2'b00:   lanes = {4{wd[7:0]}};
            2'b01:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'b0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'b0, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    assign access     = valid_in & (mem_read | mem_write);
    assign fault_cond = bad_access(funct3, mem_write, addr[1:0]);
    assign accept     = (state == IDLE) & access & ~fault_cond;
    assign lsu_stall  = (state != IDLE) | accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
            bus_err    <= 1'b0;
            cnt        <= '0;
            funct3_q   <= '0;
            lane_q     <= '0;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    fault <= access & fault_cond;
                    if (accept) begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= byte_enables(funct3, addr[1:0]);
                        dmem_wdata <= mem_write ? store_lanes(funct3, wdata) : 32'b0;
                        funct3_q   <= funct3;
                        lane_q     <= addr[1:0];
                        cnt        <= '0;
                    end
                end
                REQ: begin
                    // A grant on the last allowed cycle still completes the request.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        state    <= dmem_we ? IDLE : WAIT;
                        cnt      <= cnt + 10'd1;
                    end else if (cnt == CNT_MAX) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        load_data  <= format_load(funct3_q, lane_q, dmem_rdata);
                        load_valid <= 1'b1;
                        state      <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        bus_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
